// File: rtl/bru_pipe_pkg.sv
// Shared types for the branch resolution unit: op encodings and the result record.
// Widths here are the default build; the modules carry their own XLEN/TAG_W parameters.
package bru_pipe_pkg;

  localparam int BRU_XLEN  = 32;
  localparam int BRU_TAG_W = 5;

  typedef enum logic [2:0] {
    OP_BRU_BEQ  = 3'd0,
    OP_BRU_BLT  = 3'd1,
    OP_BRU_BLTU = 3'd2,
    OP_BRU_JAL  = 3'd3,
    OP_BRU_JALR = 3'd4
  } decode_bru_op_t;

  typedef logic [BRU_XLEN-1:0] reg_data_t;
  typedef logic [BRU_XLEN-1:0] program_counter_t;

  typedef struct packed {
    logic [BRU_TAG_W-1:0] tag;
    program_counter_t     dest_pc;
    program_counter_t     link_pc;
    logic                 taken;
    logic                 mispredict;
    logic                 misalign;
  } bru_result_t;

endpackage

// File: rtl/bru_resolve.sv
// Combinational branch resolution: condition, target, link, misalign, mispredict.
// Zero latency; no flow control of its own.
module bru_resolve
  import bru_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  decode_bru_op_t    op,
  input  logic              invert,
  input  logic              isa_c,
  input  logic [XLEN-1:0]   pc,
  input  logic              compressed,
  input  logic [XLEN-1:0]   src1,
  input  logic [XLEN-1:0]   src2,
  input  logic [XLEN-1:0]   offset,
  input  logic              pred_taken,
  input  logic [XLEN-1:0]   pred_pc,
  output logic [XLEN-1:0]   dest_pc,
  output logic [XLEN-1:0]   link_pc,
  output logic              taken,
  output logic              mispredict,
  output logic              misalign
);

  logic            cond;
  logic [XLEN-1:0] taken_pc;
  logic [XLEN-1:0] ntaken_pc;
  logic [XLEN-1:0] dest;

  always_comb begin
    cond = 1'b0;
    case (op)
      OP_BRU_BEQ:  cond = (src1 == src2);
      OP_BRU_BLT:  cond = ($signed(src1) < $signed(src2));
      OP_BRU_BLTU: cond = (src1 < src2);
      OP_BRU_JAL:  cond = 1'b1;
      OP_BRU_JALR: cond = 1'b1;
      default:     cond = 1'b0;
    endcase
  end

  assign taken     = cond ^ invert;
  assign taken_pc  = (op == OP_BRU_JALR) ? (src1 + offset) : (pc + (offset << 1));
  assign ntaken_pc = pc + (compressed ? XLEN'(2) : XLEN'(4));
  assign dest      = taken ? taken_pc : ntaken_pc;
  assign link_pc   = ntaken_pc;

  // Misalignment is judged on the raw target, before bit 0 is cleared.
  assign misalign   = ~isa_c & dest[1];
  assign dest_pc    = {dest[XLEN-1:1], 1'b0};
  assign mispredict = ~misalign & ((taken != pred_taken) | (dest_pc != pred_pc));

endmodule

// File: rtl/bru_pipe.sv
// Two-stage pipelined branch resolution unit with saturating perf counters.
// Latency 2 cycles, 1/cycle; o_ready = S1 can advance, derived from i_ready only.
module bru_pipe
  import bru_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [TAG_W-1:0]   i_tag,
  input  decode_bru_op_t     i_op,
  input  logic               i_invert,
  input  logic               i_isa_c,
  input  logic [XLEN-1:0]    i_pc,
  input  logic               i_compressed,
  input  logic [XLEN-1:0]    i_src1,
  input  logic [XLEN-1:0]    i_src2,
  input  logic [XLEN-1:0]    i_offset,
  input  logic               i_pred_taken,
  input  logic [XLEN-1:0]    i_pred_pc,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [TAG_W-1:0]   o_tag,
  output logic [XLEN-1:0]    o_dest_pc,
  output logic [XLEN-1:0]    o_link_pc,
  output logic               o_taken,
  output logic               o_mispredict,
  output logic               o_misalign,
  output logic [CNT_W-1:0]   o_br_count,
  output logic [CNT_W-1:0]   o_mispred_count
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  dest_pc;
    logic [XLEN-1:0]  link_pc;
    logic             taken;
    logic             mispredict;
    logic             misalign;
  } result_t;

  logic            s1_valid, s2_valid;
  logic            s1_adv, s2_adv, accept, fire;

  logic [TAG_W-1:0] s1_tag;
  decode_bru_op_t   s1_op;
  logic             s1_invert, s1_isa_c, s1_compressed, s1_pred_taken;
  logic [XLEN-1:0]  s1_pc, s1_src1, s1_src2, s1_offset, s1_pred_pc;

  result_t          res, s2_res;
  logic [CNT_W-1:0] br_count, mispred_count;

  assign s2_adv  = ~s2_valid | i_ready;
  assign s1_adv  = ~s1_valid | s2_adv;
  assign o_ready = s1_adv;
  assign accept  = i_valid & s1_adv;
  assign fire    = s2_valid & i_ready & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (i_flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= i_valid;
      if (s2_adv) s2_valid <= s1_valid;
    end
  end

  // Payload registers load freely; the valids above decide what is live.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_tag        <= '0;
      s1_op         <= OP_BRU_BEQ;
      s1_invert     <= 1'b0;
      s1_isa_c      <= 1'b0;
      s1_compressed <= 1'b0;
      s1_pred_taken <= 1'b0;
      s1_pc         <= '0;
      s1_src1       <= '0;
      s1_src2       <= '0;
      s1_offset     <= '0;
      s1_pred_pc    <= '0;
    end else if (accept) begin
      s1_tag        <= i_tag;
      s1_op         <= i_op;
      s1_invert     <= i_invert;
      s1_isa_c      <= i_isa_c;
      s1_compressed <= i_compressed;
      s1_pred_taken <= i_pred_taken;
      s1_pc         <= i_pc;
      s1_src1       <= i_src1;
      s1_src2       <= i_src2;
      s1_offset     <= i_offset;
      s1_pred_pc    <= i_pred_pc;
    end
  end

  bru_resolve #(.XLEN(XLEN)) u_resolve (
    .op         (s1_op),
    .invert     (s1_invert),
    .isa_c      (s1_isa_c),
    .pc         (s1_pc),
    .compressed (s1_compressed),
    .src1       (s1_src1),
    .src2       (s1_src2),
    .offset     (s1_offset),
    .pred_taken (s1_pred_taken),
    .pred_pc    (s1_pred_pc),
    .dest_pc    (res.dest_pc),
    .link_pc    (res.link_pc),
    .taken      (res.taken),
    .mispredict (res.mispredict),
    .misalign   (res.misalign)
  );
  assign res.tag = s1_tag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_res <= '0;
    end else if (s2_adv && s1_valid) begin
      s2_res <= res;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (fire) begin
      if (br_count != '1) br_count <= br_count + CNT_W'(1);
      if (s2_res.mispredict && (mispred_count != '1)) mispred_count <= mispred_count + CNT_W'(1);
    end
  end

  assign o_valid         = s2_valid;
  assign o_tag           = s2_res.tag;
  assign o_dest_pc       = s2_res.dest_pc;
  assign o_link_pc       = s2_res.link_pc;
  assign o_taken         = s2_res.taken;
  assign o_mispredict    = s2_res.mispredict;
  assign o_misalign      = s2_res.misalign;
  assign o_br_count      = br_count;
  assign o_mispred_count = mispred_count;

endmodule

// File: tb/tb_bru_pipe.sv
// Bench for bru_pipe: directed vector table through a scoreboard, plus stall, flush,
// async reset and counter saturation sequences (counters built 4 bits wide).
module tb_bru_pipe;
  import bru_pipe_pkg::*;

  localparam int XL = 32;
  localparam int TW = 5;
  localparam int CW = 4;

  logic           clk, rst_n, i_flush, i_valid, o_ready, i_ready, o_valid;
  logic [TW-1:0]  i_tag, o_tag;
  decode_bru_op_t i_op;
  logic           i_invert, i_isa_c, i_compressed, i_pred_taken;
  logic [XL-1:0]  i_pc, i_src1, i_src2, i_offset, i_pred_pc;
  logic [XL-1:0]  o_dest_pc, o_link_pc;
  logic           o_taken, o_mispredict, o_misalign;
  logic [CW-1:0]  o_br_count, o_mispred_count;

  bru_pipe #(.XLEN(XL), .TAG_W(TW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_tag(i_tag), .i_op(i_op), .i_invert(i_invert), .i_isa_c(i_isa_c), .i_pc(i_pc),
    .i_compressed(i_compressed), .i_src1(i_src1), .i_src2(i_src2), .i_offset(i_offset),
    .i_pred_taken(i_pred_taken), .i_pred_pc(i_pred_pc), .o_valid(o_valid), .i_ready(i_ready),
    .o_tag(o_tag), .o_dest_pc(o_dest_pc), .o_link_pc(o_link_pc), .o_taken(o_taken),
    .o_mispredict(o_mispredict), .o_misalign(o_misalign), .o_br_count(o_br_count),
    .o_mispred_count(o_mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    decode_bru_op_t op;
    logic inv, isa_c, comp;
    logic [XL-1:0] pc, s1, s2, off;
    logic pt;
    logic [XL-1:0] pp, e_dest, e_link;
    logic e_taken, e_mis, e_mal;
  } vec_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic [XL-1:0] dest, link;
    logic taken, mis, mal;
  } exp_t;

  vec_t    tbl[12];
  exp_t    sbq[$];
  exp_t    cur;
  int      n_cmp = 0;
  int      n_err = 0;
  logic [CW-1:0] m_br = '0, m_mis = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input decode_bru_op_t op, input logic inv, input logic isa_c,
                              input logic comp, input logic [XL-1:0] pc, input logic [XL-1:0] s1,
                              input logic [XL-1:0] s2, input logic [XL-1:0] off, input logic pt,
                              input logic [XL-1:0] pp, input logic [XL-1:0] dest,
                              input logic [XL-1:0] link, input logic t, input logic m, input logic a);
    vec_t v;
    v.op = op; v.inv = inv; v.isa_c = isa_c; v.comp = comp; v.pc = pc; v.s1 = s1; v.s2 = s2;
    v.off = off; v.pt = pt; v.pp = pp; v.e_dest = dest; v.e_link = link;
    v.e_taken = t; v.e_mis = m; v.e_mal = a;
    return v;
  endfunction

  // Scoreboard: push on accepted handshake, pop on consumed result, drop all on flush.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && i_ready && !i_flush) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got tag %0h expected no result", o_tag);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("tag", o_tag, e.tag);
          chk("dest_pc", o_dest_pc, e.dest);
          chk("link_pc", o_link_pc, e.link);
          chk("taken", o_taken, e.taken);
          chk("mispredict", o_mispredict, e.mis);
          chk("misalign", o_misalign, e.mal);
          chk("br_count", o_br_count, m_br);
          chk("mispred_count", o_mispred_count, m_mis);
          if (m_br != '1) m_br = m_br + 1'b1;
          if (e.mis && m_mis != '1) m_mis = m_mis + 1'b1;
        end
      end
      if (i_flush) sbq.delete();
      else if (i_valid && o_ready) sbq.push_back(cur);
    end
  end

  task automatic drive(input vec_t v, input logic [TW-1:0] tag);
    i_op = v.op; i_invert = v.inv; i_isa_c = v.isa_c; i_compressed = v.comp;
    i_pc = v.pc; i_src1 = v.s1; i_src2 = v.s2; i_offset = v.off;
    i_pred_taken = v.pt; i_pred_pc = v.pp; i_tag = tag;
    cur.tag = tag; cur.dest = v.e_dest; cur.link = v.e_link;
    cur.taken = v.e_taken; cur.mis = v.e_mis; cur.mal = v.e_mal;
    i_valid = 1'b1;
  endtask

  task automatic send(input vec_t v, input logic [TW-1:0] tag);
    int   b;
    logic acc;
    drive(v, tag);
    b = 0;
    do begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      b++;
    end while (!acc && b < 100);
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no acceptance expected o_ready within 100 cycles");
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sbq.size() != 0 && b < 200) begin
      @(posedge clk);
      b++;
    end
    #1;
    chk("drain_empty", sbq.size(), 0);
  endtask

  logic [TW-1:0] hold_tag;
  logic [XL-1:0] hold_dest;
  logic [CW-1:0] save_br, save_mis;

  initial begin
    rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_tag = '0; i_op = OP_BRU_BEQ; i_invert = 1'b0; i_isa_c = 1'b0; i_pc = '0;
    i_compressed = 1'b0; i_src1 = '0; i_src2 = '0; i_offset = '0;
    i_pred_taken = 1'b0; i_pred_pc = '0;
    cur = '{default: '0};

    //          op            inv isc cmp pc          src1          src2          off           pt pp          dest        link        t  m  a
    tbl[0]  = mk(OP_BRU_BEQ,  0, 1, 0, 32'h100,  32'h5,        32'h5,        32'h10,       1, 32'h120,  32'h120,  32'h104,  1, 0, 0);
    tbl[1]  = mk(OP_BRU_BLT,  0, 1, 0, 32'h100,  32'hFFFFFFFF, 32'h1,        32'h10,       0, 32'h104,  32'h120,  32'h104,  1, 1, 0);
    tbl[2]  = mk(OP_BRU_BLTU, 0, 1, 0, 32'h100,  32'hFFFFFFFF, 32'h1,        32'h10,       0, 32'h104,  32'h104,  32'h104,  0, 0, 0);
    tbl[3]  = mk(OP_BRU_JALR, 0, 0, 0, 32'h100,  32'h2001,     32'h0,        32'h1,        1, 32'h2002, 32'h2002, 32'h104,  1, 0, 1);
    tbl[4]  = mk(OP_BRU_JALR, 0, 1, 0, 32'h100,  32'h2001,     32'h0,        32'h1,        1, 32'h2002, 32'h2002, 32'h104,  1, 0, 0);
    tbl[5]  = mk(OP_BRU_BEQ,  1, 1, 1, 32'h200,  32'h5,        32'h6,        32'hFFFFFFFC, 0, 32'h202,  32'h1F8,  32'h202,  1, 1, 0);
    tbl[6]  = mk(OP_BRU_JAL,  0, 1, 1, 32'h300,  32'h0,        32'h0,        32'h80,       1, 32'h400,  32'h400,  32'h302,  1, 0, 0);
    tbl[7]  = mk(OP_BRU_BLT,  1, 0, 0, 32'h1000, 32'h2,        32'hFFFFFFFE, 32'h8,        1, 32'h1010, 32'h1010, 32'h1004, 1, 0, 0);
    tbl[8]  = mk(decode_bru_op_t'(3'd7), 0, 0, 0, 32'h40, 32'h9, 32'h9,     32'h8,        0, 32'h44,   32'h44,   32'h44,   0, 0, 0);
    tbl[9]  = mk(OP_BRU_JAL,  0, 0, 0, 32'h10,   32'h0,        32'h0,        32'h1,        0, 32'h0,    32'h12,   32'h14,   1, 0, 1);
    tbl[10] = mk(OP_BRU_BLTU, 0, 0, 0, 32'h500,  32'h1,        32'h2,        32'h4,        1, 32'h50C,  32'h508,  32'h504,  1, 1, 0);
    tbl[11] = mk(OP_BRU_JALR, 0, 1, 0, 32'h600,  32'h3003,     32'h0,        32'h0,        1, 32'h3002, 32'h3002, 32'h604,  1, 0, 0);

    #12;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_ready", o_ready, 1);
    chk("rst_o_tag", o_tag, 0);
    chk("rst_o_dest_pc", o_dest_pc, 0);
    chk("rst_o_link_pc", o_link_pc, 0);
    chk("rst_flags", {o_taken, o_mispredict, o_misalign}, 0);
    chk("rst_br_count", o_br_count, 0);
    chk("rst_mispred_count", o_mispred_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-cycle latency of a single request
    send(tbl[0], 5'h01);
    @(negedge clk);
    chk("latency_after_1", o_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("latency_after_2", o_valid, 1);
    @(posedge clk);
    #1;
    chk("br_count_first", o_br_count, 1);
    chk("mispred_count_first", o_mispred_count, 0);

    // Directed table, back-to-back
    for (int i = 0; i < 12; i++) send(tbl[i], TW'(i + 2));
    drain();

    // Stall: four back-to-back requests with the consumer blocked
    i_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send(tbl[k + 6], TW'(5'h18 + k));
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          if (j == 0) begin
            hold_tag  = o_tag;
            hold_dest = o_dest_pc;
            chk("stall_head_tag", o_tag, 5'h18);
          end else begin
            chk("stall_tag_stable", o_tag, hold_tag);
            chk("stall_dest_stable", o_dest_pc, hold_dest);
          end
          chk("stall_o_ready", o_ready, 0);
          chk("stall_o_valid", o_valid, 1);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();

    // Flush with both stages full and a new request handshaking
    i_ready = 1'b0;
    send(tbl[0], 5'h10);
    send(tbl[2], 5'h11);
    save_br  = m_br;
    save_mis = m_mis;
    drive(tbl[6], 5'h12);
    i_flush = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    chk("flush_hs_ready", o_ready, 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("flush_o_valid", o_valid, 0);
    end
    chk("flush_br_count", o_br_count, save_br);
    chk("flush_mispred_count", o_mispred_count, save_mis);
    chk("flush_queue_empty", sbq.size(), 0);

    // Async reset mid-operation
    send(tbl[1], 5'h07);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_o_valid", o_valid, 0);
    chk("arst_o_ready", o_ready, 1);
    chk("arst_br_count", o_br_count, 0);
    chk("arst_mispred_count", o_mispred_count, 0);
    chk("arst_dest_pc", o_dest_pc, 0);
    sbq.delete();
    m_br  = '0;
    m_mis = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("post_rst_idle", o_valid, 0);
    end
    @(posedge clk);
    #1;

    // Saturation of the 4-bit counters
    for (int k = 0; k < 20; k++) send(tbl[1], TW'(k));
    drain();
    chk("sat_br_count", o_br_count, 4'hF);
    chk("sat_mispred_count", o_mispred_count, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
